// File: rtl/queue_pkg.sv
// queue_pkg: shared queue RAM types and constants for the pathfinding datapath
package queue_pkg;
  localparam int EMPTY_ID = 0;
  localparam logic [15:0] COST_INF = '1;
  typedef enum logic [1:0] {MODE_MIN, MODE_MATCH, MODE_FREE, MODE_RSVD} scan_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_e;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       blocked;
  } map_node;
  typedef struct packed {
    logic [15:0] node_id;
    logic [15:0] parent_id;
    logic [15:0] current_cost;
    logic [15:0] est_cost;
  } node_info;
endpackage

// File: rtl/queue_scan_engine_if.sv
// queue_scan_engine_if: controller and queue RAM signals of the scan engine
interface queue_scan_engine_if #(
  parameter int MAX_NODES = 100,
  parameter int ID_W = 16,
  parameter int COST_W = 16
);
  localparam int ADDR_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  logic              start;
  logic [1:0]        mode;
  logic [ID_W-1:0]   key_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [ID_W-1:0]   rd_id;
  logic [COST_W-1:0] rd_cost;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] result_addr;
  logic [ID_W-1:0]   result_id;
  logic [COST_W-1:0] result_cost;
  logic [ADDR_W:0]   scanned;
  modport master (
    output start, mode, key_id, rd_id, rd_cost,
    input  rd_addr, busy, done, found, result_addr, result_id, result_cost, scanned
  );
  modport slave (
    input  start, mode, key_id, rd_id, rd_cost,
    output rd_addr, busy, done, found, result_addr, result_id, result_cost, scanned
  );
endinterface

// File: rtl/queue_scan_tag_pipe.sv
// queue_scan_tag_pipe: valid+address tag delay line matching the RAM read latency
module queue_scan_tag_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_v,
  input  logic [ADDR_W-1:0] in_a,
  output logic              out_v,
  output logic [ADDR_W-1:0] out_a
);
  logic [RD_LAT-1:0]        v_q, v_d;
  logic [RD_LAT*ADDR_W-1:0] a_q, a_d;
  always_comb begin
    v_d = flush ? '0 : (v_q << 1) | RD_LAT'(in_v);
    a_d = (a_q << ADDR_W) | (RD_LAT*ADDR_W)'(in_a);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
    end
  end
  assign out_v = v_q[RD_LAT-1];
  assign out_a = a_q[RD_LAT*ADDR_W-1 -: ADDR_W];
endmodule

// File: rtl/queue_scan_engine.sv
// queue_scan_engine: pipelined MIN / MATCH / FREE scan over the node queue RAM
module queue_scan_engine
  import queue_pkg::*;
#(
  parameter int MAX_NODES = 100,
  parameter int ID_W = 16,
  parameter int COST_W = 16,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  queue_scan_engine_if.slave bus
);
  localparam int ADDR_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_NODES - 1);
  scan_state_e       state_q, state_d;
  scan_mode_e        mode_q, mode_d;
  logic [ID_W-1:0]   key_q, key_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              issue_q, issue_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [COST_W-1:0] res_cost_q, res_cost_d;
  logic [ADDR_W:0]   scanned_q, scanned_d;
  logic              beat_v, term, hit, flush, id_empty;
  logic [ADDR_W-1:0] beat_a;
  assign id_empty = bus.rd_id == ID_W'(EMPTY_ID);
  assign flush = state_q != S_SCAN || term;
  queue_scan_tag_pipe #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) u_tag (
    .clk(clk),
    .rst(reset),
    .flush(flush),
    .in_v(state_q == S_SCAN && issue_q),
    .in_a(rd_addr_q),
    .out_v(beat_v),
    .out_a(beat_a)
  );
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    key_d = key_q;
    rd_addr_d = rd_addr_q;
    issue_d = issue_q;
    found_d = found_q;
    res_addr_d = res_addr_q;
    res_id_d = res_id_q;
    res_cost_d = res_cost_q;
    scanned_d = scanned_q;
    term = 1'b0;
    hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        rd_addr_d = '0;
        if (bus.start) begin
          mode_d = scan_mode_e'(bus.mode);
          key_d = bus.key_id;
          issue_d = 1'b1;
          found_d = 1'b0;
          res_addr_d = '0;
          res_id_d = '0;
          res_cost_d = '1;
          scanned_d = '0;
          state_d = (mode_d == MODE_MATCH && bus.key_id == ID_W'(EMPTY_ID)) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        // address saturates at the last slot; issue_q stops further tags
        rd_addr_d = (rd_addr_q == LAST) ? rd_addr_q : rd_addr_q + 1'b1;
        issue_d = issue_q && rd_addr_q != LAST;
        if (beat_v) begin
          scanned_d = scanned_q + 1'b1;
          case (mode_q)
            MODE_MIN: begin
              hit = !id_empty && bus.rd_cost < res_cost_q;
              term = id_empty;
            end
            MODE_MATCH: begin
              hit = bus.rd_id == key_q;
              term = hit || id_empty;
            end
            MODE_FREE: begin
              hit = id_empty;
              term = id_empty;
            end
            default: ;
          endcase
          if (hit) begin
            found_d = 1'b1;
            res_addr_d = beat_a;
            res_id_d = bus.rd_id;
            res_cost_d = bus.rd_cost;
          end
        end
        term = term || (beat_v && beat_a == LAST) || mode_q == MODE_RSVD;
        state_d = term ? S_DONE : S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= MODE_MIN;
      key_q <= '0;
      rd_addr_q <= '0;
      issue_q <= 1'b0;
      found_q <= 1'b0;
      res_addr_q <= '0;
      res_id_q <= '0;
      res_cost_q <= '1;
      scanned_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      key_q <= key_d;
      rd_addr_q <= rd_addr_d;
      issue_q <= issue_d;
      found_q <= found_d;
      res_addr_q <= res_addr_d;
      res_id_q <= res_id_d;
      res_cost_q <= res_cost_d;
      scanned_q <= scanned_d;
    end
  end
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE;
  assign bus.found = found_q;
  assign bus.result_addr = res_addr_q;
  assign bus.result_id = res_id_q;
  assign bus.result_cost = res_cost_q;
  assign bus.scanned = scanned_q;
endmodule

// File: tb/tb_queue_scan_engine.sv
// tb_queue_scan_engine: randomized and directed scans on two configurations against a slot-by-slot reference model
module tb_queue_scan_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  queue_scan_engine_if #(.MAX_NODES(8)) bus_a ();
  queue_scan_engine_if #(.MAX_NODES(4)) bus_b ();
  queue_scan_engine #(.MAX_NODES(8), .ID_W(16), .COST_W(16), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  queue_scan_engine #(.MAX_NODES(4), .ID_W(16), .COST_W(16), .RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));
  logic [15:0] id_a [8];
  logic [15:0] cost_a [8];
  logic [15:0] id_b [4];
  logic [15:0] cost_b [4];
  logic [15:0] b_id1, b_cost1;
  always_ff @(posedge clk) begin
    bus_a.rd_id <= id_a[bus_a.rd_addr];
    bus_a.rd_cost <= cost_a[bus_a.rd_addr];
    b_id1 <= id_b[bus_b.rd_addr];
    b_cost1 <= cost_b[bus_b.rd_addr];
    bus_b.rd_id <= b_id1;
    bus_b.rd_cost <= b_cost1;
  end
  int errors = 0;
  int checks = 0;
  int sel = 0;
  int o_done, o_busy, o_found, o_addr, o_id, o_cost, o_scanned, o_rd_addr;
  always_comb begin
    o_done = sel != 0 ? int'(bus_b.done) : int'(bus_a.done);
    o_busy = sel != 0 ? int'(bus_b.busy) : int'(bus_a.busy);
    o_found = sel != 0 ? int'(bus_b.found) : int'(bus_a.found);
    o_addr = sel != 0 ? int'(bus_b.result_addr) : int'(bus_a.result_addr);
    o_id = sel != 0 ? int'(bus_b.result_id) : int'(bus_a.result_id);
    o_cost = sel != 0 ? int'(bus_b.result_cost) : int'(bus_a.result_cost);
    o_scanned = sel != 0 ? int'(bus_b.scanned) : int'(bus_a.scanned);
    o_rd_addr = sel != 0 ? int'(bus_b.rd_addr) : int'(bus_a.rd_addr);
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input int s, input bit st, input int m, input int k);
    if (s != 0) begin
      bus_b.start = st;
      bus_b.mode = 2'(m);
      bus_b.key_id = 16'(k);
    end else begin
      bus_a.start = st;
      bus_a.mode = 2'(m);
      bus_a.key_id = 16'(k);
    end
  endtask
  task automatic fill(input int s, input int i, input int idv, input int cv);
    if (s != 0) begin
      id_b[i] = 16'(idv);
      cost_b[i] = 16'(cv);
    end else begin
      id_a[i] = 16'(idv);
      cost_a[i] = 16'(cv);
    end
  endtask
  // walks the queue slot by slot applying the scan rules directly
  task automatic model(input int s, input int m, input int k,
                       output int f, output int a, output int id, output int c,
                       output int sc, output int d);
    int n, lat, mid, mc;
    bit stop;
    n = s != 0 ? 4 : 8;
    lat = s != 0 ? 2 : 1;
    f = 0; a = 0; id = 0; c = 65535; sc = 0;
    if (m == 1 && k == 0) begin
      d = 1;
      return;
    end
    if (m == 3) begin
      d = 2;
      return;
    end
    d = n + lat + 1;
    sc = n;
    for (int j = 0; j < n; j++) begin
      mid = s != 0 ? int'(id_b[j]) : int'(id_a[j]);
      mc = s != 0 ? int'(cost_b[j]) : int'(cost_a[j]);
      stop = 0;
      if (m == 0) begin
        if (mid == 0) stop = 1;
        else if (mc < c) begin f = 1; a = j; id = mid; c = mc; end
      end else if (m == 1) begin
        if (mid == k) begin f = 1; a = j; id = mid; c = mc; stop = 1; end
        else if (mid == 0) stop = 1;
      end else if (mid == 0) begin
        f = 1; a = j; id = 0; c = mc; stop = 1;
      end
      if (stop) begin
        d = j + lat + 2;
        sc = j + 1;
        break;
      end
    end
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_busy"}, o_busy, 0);
    chk({p, "_done"}, o_done, 0);
    chk({p, "_found"}, o_found, 0);
    chk({p, "_rd_addr"}, o_rd_addr, 0);
    chk({p, "_addr"}, o_addr, 0);
    chk({p, "_id"}, o_id, 0);
    chk({p, "_scanned"}, o_scanned, 0);
    chk({p, "_cost"}, o_cost, 65535);
  endtask
  task automatic run(input string p, input int s, input int m, input int k, input bit poke);
    int f, a, id, c, sc, d, n, cyc, quiet, ra;
    sel = s;
    n = s != 0 ? 4 : 8;
    model(s, m, k, f, a, id, c, sc, d);
    @(posedge clk); #1 drive(s, 1, m, k);
    @(posedge clk); #1 drive(s, 0, 0, 0);
    cyc = 1;
    chk({p, "_busy1"}, o_busy, 1);
    if (poke) begin
      @(posedge clk); #1 cyc = 2;
      drive(s, 1, 2, 5);
      @(posedge clk); #1 cyc = 3;
      drive(s, 0, 0, 0);
    end
    while (o_done == 0 && cyc < 100) begin
      @(posedge clk); #1 cyc++;
    end
    chk({p, "_done_cyc"}, cyc, d);
    chk({p, "_found"}, o_found, f);
    chk({p, "_scanned"}, o_scanned, sc);
    ra = d == 1 ? 0 : (d - 1 < n - 1 ? d - 1 : n - 1);
    chk({p, "_rd_addr"}, o_rd_addr, ra);
    if (f != 0) begin
      chk({p, "_addr"}, o_addr, a);
      chk({p, "_id"}, o_id, id);
      chk({p, "_cost"}, o_cost, c);
    end else if (m == 0) chk({p, "_cost_inf"}, o_cost, 65535);
    quiet = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done != 0 || o_busy != 0) quiet++;
    end
    chk({p, "_single_done"}, quiet, 0);
    chk({p, "_found_held"}, o_found, f);
    chk({p, "_scanned_held"}, o_scanned, sc);
  endtask
  int seen, rs, rn, rm, rk, ri, rc;
  initial begin
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int j = 0; j < 8; j++) fill(0, j, j + 1, 100);
    for (int j = 0; j < 4; j++) fill(1, j, j + 1, 100);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sel = 0;
    #1 chk_reset("rst_a");
    fill(0, 0, 1, 50); fill(0, 1, 2, 20); fill(0, 2, 3, 20); fill(0, 3, 4, 70);
    fill(0, 4, 5, 30); fill(0, 5, 0, 10);
    run("min_tie", 0, 0, 0, 0);
    fill(1, 0, 3, 11); fill(1, 1, 9, 12); fill(1, 2, 7, 13); fill(1, 3, 4, 14);
    run("match7", 1, 1, 7, 0);
    for (int j = 0; j < 8; j++) fill(0, j, j + 1, 5 * j);
    run("free_full", 0, 2, 0, 0);
    run("match_key0", 0, 1, 0, 0);
    run("mode_rsvd", 0, 3, 0, 0);
    for (int j = 0; j < 4; j++) fill(1, j, j + 2, 65535);
    run("min_inf", 1, 0, 0, 0);
    sel = 0;
    @(posedge clk); #1 drive(0, 1, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 chk_reset("rst_mid");
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (o_done != 0 || o_busy != 0) seen++;
    end
    chk("rst_quiet", seen, 0);
    fill(0, 3, 0, 1);
    run("start_busy", 0, 0, 0, 1);
    for (int t = 0; t < 40; t++) begin
      rs = t % 2;
      rn = rs != 0 ? 4 : 8;
      rm = $urandom_range(0, 3);
      rk = $urandom_range(0, 6);
      for (int j = 0; j < rn; j++) begin
        ri = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 6);
        rc = ($urandom_range(0, 9) == 0) ? 65535 : $urandom_range(0, 40);
        fill(rs, j, ri, rc);
      end
      run($sformatf("rnd%0d", t), rs, rm, rk, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
